// File: rtl/pingpong_pkg.sv
// Shared types and width helpers for the ping-pong buffer controller.
package pingpong_pkg;

    localparam int NUM_BANKS = 2;

    // Life cycle of one bank: written, closed, read out, released.
    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // Bits needed to address 'depth' entries (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to hold a count from 0 up to and including 'depth'.
    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// Simple dual-port bank RAM: one write port, one synchronous read port.
module pp_bank_ram
    import pingpong_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 50,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on we; registered read data appears one cycle after re.
    // NOTE: storage and read register have no reset so they map onto block RAM; nothing downstream consumes them before a valid read.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Two-bank ping-pong buffer: packs RATIO input words per output word, fills one
// bank while the other drains through a 2-entry skid output stage.
module pingpong_buf_ctrl
    import pingpong_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int RATIO = 2,
    parameter int DEPTH = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IN_W*RATIO-1:0] out_data,
    output logic                  out_last,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic [1:0]            bank_full
);

    localparam int OUT_W     = IN_W * RATIO;
    localparam int OUT_DEPTH = DEPTH / RATIO;
    localparam int AW        = addr_width(OUT_DEPTH);
    localparam int LW        = len_width(OUT_DEPTH);
    localparam int LANE_W    = addr_width(RATIO);
    localparam logic [AW-1:0]     LAST_ADDR = AW'(OUT_DEPTH - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] data;
    } out_word_t;

    bank_state_t       bank_state_q [NUM_BANKS];
    bank_state_t       bank_state_d [NUM_BANKS];
    logic [LW-1:0]     bank_len_q   [NUM_BANKS];
    logic [OUT_W-1:0]  ram_rdata    [NUM_BANKS];

    logic              alive_q;
    logic              wr_bank_q, iss_bank_q, rd_bank_q, rd_src_q;
    logic [AW-1:0]     wr_addr_q, iss_addr_q;
    logic [LANE_W-1:0] wr_lane_q;
    logic [OUT_W-1:0]  pack_q, pack_merged;
    logic              rd_vld_q, rd_last_q;
    out_word_t         head_q, tail_q, ram_word;
    logic              head_vld_q, tail_vld_q;

    // Writer-side decode. A close happens either on the last word of the bank or on
    // a flush that has at least one word (counting one accepted this cycle).
    logic in_fire, lane_last, close_full, close_flush, wr_close, ram_we;
    logic [LW-1:0] close_len;
    assign in_ready    = alive_q && (bank_state_q[wr_bank_q] == BANK_EMPTY ||
                                     bank_state_q[wr_bank_q] == BANK_FILLING);
    assign in_fire     = in_valid && in_ready;
    assign lane_last   = (wr_lane_q == LAST_LANE);
    assign close_full  = in_fire && lane_last && (wr_addr_q == LAST_ADDR);
    assign close_flush = flush && !close_full && (in_fire || wr_lane_q != '0 || wr_addr_q != '0);
    assign wr_close    = close_full || close_flush;
    assign ram_we      = (in_fire && lane_last) || (close_flush && (in_fire || wr_lane_q != '0));
    assign close_len   = LW'(wr_addr_q) + LW'(ram_we);

    // Reader-side decode. Reads run ahead of the output bank so the next bank starts
    // without a bubble; a new bank is only entered once it is FULL.
    logic pop, push, last_hs, room, iss_ok, issue, iss_last;
    assign pop      = head_vld_q && out_ready;
    assign push     = rd_vld_q;
    assign last_hs  = pop && head_q.last;
    assign room     = ({1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, rd_vld_q}) < (2'd2 + {1'b0, pop});
    assign iss_ok   = (iss_addr_q == '0) ? (bank_state_q[iss_bank_q] == BANK_FULL)
                                         : (bank_state_q[iss_bank_q] == BANK_DRAINING);
    assign issue    = iss_ok && room;
    assign iss_last = (LW'(iss_addr_q) + LW'(1)) == bank_len_q[iss_bank_q];
    assign ram_word = '{last: rd_last_q, data: ram_rdata[rd_src_q]};

    // Merge the current input word into its lane; untouched upper lanes stay zero.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pack_merged = pack_q;
        if (in_fire) pack_merged[wr_lane_q*IN_W +: IN_W] = in_data;
    end

    // Per-bank next state; the transitions on one edge always hit different banks.
    always_comb begin
        bank_state_d = bank_state_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (in_fire && wr_bank_q == 1'(b) && bank_state_q[b] == BANK_EMPTY)
                bank_state_d[b] = BANK_FILLING;
            if (wr_close && wr_bank_q == 1'(b))
                bank_state_d[b] = BANK_FULL;
            if (issue && iss_addr_q == '0 && iss_bank_q == 1'(b))
                bank_state_d[b] = BANK_DRAINING;
            if (last_hs && rd_bank_q == 1'(b))
                bank_state_d[b] = BANK_EMPTY;
        end
    end

    // Bank state registers and the post-reset enable for in_ready.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_state_q <= '{default: BANK_EMPTY};
            alive_q      <= 1'b0;
        end else begin
            bank_state_q <= bank_state_d;
            alive_q      <= 1'b1;
        end
    end

    // Writer: lane/address counters, pack register, bank length capture on close.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_lane_q  <= '0;
            pack_q     <= '0;
            bank_len_q <= '{default: '0};
        end else if (wr_close) begin
            bank_len_q[wr_bank_q] <= close_len;
            wr_bank_q <= ~wr_bank_q;
            wr_addr_q <= '0;
            wr_lane_q <= '0;
            pack_q    <= '0;
        end else if (in_fire) begin
            if (lane_last) begin
                wr_lane_q <= '0;
                wr_addr_q <= wr_addr_q + 1'b1;
                pack_q    <= '0;
            end else begin
                wr_lane_q <= wr_lane_q + 1'b1;
                pack_q    <= pack_merged;
            end
        end
    end

    // Read issue pointer, RAM-stage tags and the output-side bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_bank_q <= 1'b0;
            iss_addr_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_src_q   <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            rd_vld_q  <= issue;
            rd_last_q <= issue && iss_last;
            if (issue) begin
                rd_src_q <= iss_bank_q;
                if (iss_last) begin
                    iss_bank_q <= ~iss_bank_q;
                    iss_addr_q <= '0;
                end else begin
                    iss_addr_q <= iss_addr_q + 1'b1;
                end
            end
            if (last_hs) rd_bank_q <= ~rd_bank_q;
        end
    end

    // Two-entry skid: head drives the output and only moves on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else if (pop) begin
            if (tail_vld_q) begin
                head_q     <= tail_q;
                tail_vld_q <= push;
                if (push) tail_q <= ram_word;
            end else begin
                head_vld_q <= push;
                if (push) head_q <= ram_word;
            end
        end else if (push) begin
            if (head_vld_q) begin
                tail_q     <= ram_word;
                tail_vld_q <= 1'b1;
            end else begin
                head_q     <= ram_word;
                head_vld_q <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        pp_bank_ram #(
            .WIDTH (OUT_W),
            .DEPTH (OUT_DEPTH)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we && wr_bank_q == 1'(b)),
            .waddr (wr_addr_q),
            .wdata (pack_merged),
            .re    (issue && iss_bank_q == 1'(b)),
            .raddr (iss_addr_q),
            .rdata (ram_rdata[b])
        );
        assign bank_full[b] = (bank_state_q[b] == BANK_FULL) || (bank_state_q[b] == BANK_DRAINING);
    end

    assign out_valid = head_vld_q;
    assign out_data  = head_q.data;
    assign out_last  = head_q.last;
    assign wr_bank   = wr_bank_q;
    assign rd_bank   = rd_bank_q;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Self-checking bench for pingpong_buf_ctrl against a byte-list packing model.
module tb_pingpong_buf_ctrl;

    localparam int IN_W  = 8;
    localparam int RATIO = 2;
    localparam int DEPTH = 100;
    localparam int OUT_W = IN_W * RATIO;

    logic             clk, rst_n;
    logic             in_valid, in_ready, flush;
    logic [IN_W-1:0]  in_data;
    logic             out_valid, out_ready, out_last;
    logic [OUT_W-1:0] out_data;
    logic             wr_bank, rd_bank;
    logic [1:0]       bank_full;

    int checks = 0;
    int errors = 0;
    int stall_err = 0;

    // Model: bytes of the bank being filled, expected and observed {last,data} words.
    logic [IN_W-1:0]  cur_q [$];
    logic [OUT_W:0]   exp_q [$];
    logic [OUT_W:0]   got_q [$];
    logic             model_wr_bank = 1'b0;
    logic             prev_stall = 1'b0;
    logic             prev_last = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;

    pingpong_buf_ctrl #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank),
        .bank_full (bank_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // A closed bank becomes ceil(n/RATIO) words, first byte in the low lane,
    // missing high lanes zero, last flag on the final word.
    function automatic void close_bank();
        int n;
        int nw;
        n  = cur_q.size();
        nw = (n + RATIO - 1) / RATIO;
        for (int j = 0; j < nw; j++) begin
            logic [OUT_W-1:0] w;
            w = '0;
            for (int k = 0; k < RATIO; k++)
                if (RATIO * j + k < n) w[k*IN_W +: IN_W] = cur_q[RATIO * j + k];
            exp_q.push_back({(j == nw - 1), w});
        end
        cur_q.delete();
        model_wr_bank = ~model_wr_bank;
    endfunction

    function automatic void model_reset();
        cur_q.delete();
        exp_q.delete();
        got_q.delete();
        model_wr_bank = 1'b0;
        prev_stall = 1'b0;
        stall_err = 0;
    endfunction

    // One clock: observe handshakes mid-cycle, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (in_valid && in_ready) begin
                cur_q.push_back(in_data);
                if (cur_q.size() == DEPTH) close_bank();
            end
            if (flush && cur_q.size() != 0) close_bank();
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stall_err++;
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [IN_W-1:0] b);
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 400 && !done; c++) begin
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int budget, input logic rand_ready);
        for (int c = 0; c < budget && got_q.size() < n; c++) begin
            if (rand_ready) out_ready = 1'($urandom_range(1));
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, wr_bank, rd_bank, bank_full, out_data} !== '0)
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_last=%b wr=%b rd=%b full=%b data=%h, all required 0",
                     in_ready, out_valid, out_last, wr_bank, rd_bank, bank_full, out_data);
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_stream_default();
        model_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) send_byte(IN_W'(i));
        drain(100, 500, 1'b0);
        checks++;
        if (got_q.size() != 100) begin
            errors++;
            $display("FAIL stream_count: got %0d words required 100", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stream_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q.size() == 100 && (got_q[0] !== 17'h0_0100 || got_q[49] !== 17'h1_6362 || got_q[99] !== 17'h1_c7c6)) begin
            errors++;
            $display("FAIL stream_known_words: got %h %h %h required 00100 16362 1c7c6", got_q[0], got_q[49], got_q[99]);
        end
        checks++;
        if ({wr_bank, rd_bank, bank_full} !== 4'b0000) begin
            errors++;
            $display("FAIL stream_banks_after: wr=%b rd=%b full=%b required 0 0 00", wr_bank, rd_bank, bank_full);
        end
    endtask

    task automatic test_backpressure();
        int  cycles;
        int  n0;
        logic ir;
        logic seen_last0;
        model_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 200; i++) send_byte(IN_W'($urandom));
        repeat (4) tick();
        checks++;
        if (in_ready !== 1'b0 || bank_full !== 2'b11) begin
            errors++;
            $display("FAIL bp_blocked: in_ready=%b full=%b required 0 11", in_ready, bank_full);
        end
        out_ready  = 1'b1;
        cycles     = 0;
        seen_last0 = 1'b0;
        for (int c = 0; c < 300 && got_q.size() < 100; c++) begin
            n0 = got_q.size();
            ir = in_ready;
            tick();
            cycles++;
            if (n0 == 49 && got_q.size() == 50) begin
                seen_last0 = 1'b1;
                checks++;
                if (ir !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_turnaround: in_ready at last handshake=%b after=%b required 0 1", ir, in_ready);
                end
            end
        end
        checks++;
        if (!seen_last0 || got_q.size() != 100 || cycles != 100) begin
            errors++;
            $display("FAIL bp_throughput: words=%0d cycles=%0d bank0_end_seen=%b required 100 100 1",
                     got_q.size(), cycles, seen_last0);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL bp_stall_hold: %0d unstable stalled cycles, required 0", stall_err);
        end
    endtask

    task automatic test_flush_partial();
        logic [OUT_W:0] want [3];
        model_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(IN_W'(8'ha1 + i));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || wr_bank !== 1'b1) begin
            errors++;
            $display("FAIL flush_close_edge: out_valid=%b wr_bank=%b required 0 1", out_valid, wr_bank);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_latency_1: out_valid=%b required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_latency_2: out_valid=%b required 1", out_valid);
        end
        drain(3, 50, 1'b0);
        want[0] = 17'h0_a2a1;
        want[1] = 17'h0_a4a3;
        want[2] = 17'h1_00a5;
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL flush_count: got %0d words required 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin
                errors++;
                $display("FAIL flush_word[%0d]: got %h required %h", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        checks++;
        if (wr_bank !== model_wr_bank || bank_full !== 2'b00 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: wr=%b full=%b out_valid=%b in_ready=%b required %b 00 0 1",
                     wr_bank, bank_full, out_valid, in_ready, model_wr_bank);
        end
    endtask

    task automatic test_random();
        int   sent;
        logic acc;
        model_reset();
        model_wr_bank = wr_bank === 1'b1;
        sent = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = IN_W'($urandom);
            out_ready = 1'($urandom_range(1));
            flush     = ($urandom_range(39) == 0);
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        drain(exp_q.size(), 8000, 1'b1);
        checks++;
        if (sent != 1000 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: sent=%0d got %0d words required 1000 sent and %0d words",
                     sent, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_err != 0 || wr_bank !== model_wr_bank) begin
            errors++;
            $display("FAIL rand_stall_bank: unstable=%0d wr_bank=%b required 0 %b", stall_err, wr_bank, model_wr_bank);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b0;
        for (int c = 0; c < 400 && in_ready; c++) begin
            in_valid = 1'b1;
            in_data  = IN_W'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, wr_bank, rd_bank, bank_full, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_drain: in_ready=%b out_valid=%b out_last=%b wr=%b rd=%b full=%b data=%h, all required 0",
                     in_ready, out_valid, out_last, wr_bank, rd_bank, bank_full, out_data);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        for (int i = 0; i < 100; i++) send_byte(IN_W'($urandom));
        drain(50, 300, 1'b0);
        checks++;
        if (got_q.size() != 50 || exp_q.size() != 50) begin
            errors++;
            $display("FAIL post_reset_count: got %0d words model %0d required 50", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL post_reset_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({wr_bank, rd_bank, bank_full} !== 4'b1100) begin
            errors++;
            $display("FAIL post_reset_banks: wr=%b rd=%b full=%b required 1 1 00", wr_bank, rd_bank, bank_full);
        end
    endtask

    initial begin
        test_reset();
        test_stream_default();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_random();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
